// File: rtl/vic_pkg.sv
// Shared constants for the vectored interrupt controller: source count, ID width
// and the per-source trigger-mode encoding.
package vic_pkg;
  localparam int N_SRC    = 31;
  localparam int IRQ_ID_W = 5;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;
endpackage

// File: rtl/vic_src_cond_if.sv
// Signal bundle between the interrupt sources/CPU side and the source conditioner.
// i_ack is a single-cycle strobe with no backpressure; i_ack_id is only meaningful
// in the cycle i_ack is high. Outputs are valid every cycle, nothing is held off.
interface vic_src_cond_if #(
  parameter int N_SRC = vic_pkg::N_SRC
);
  import vic_pkg::*;

  logic [N_SRC-1:0]    i_irq_raw;
  logic [N_SRC-1:0]    i_mode;
  logic [N_SRC-1:0]    i_mask;
  logic [N_SRC-1:0]    i_sw_set;
  logic                i_ack;
  logic [IRQ_ID_W-1:0] i_ack_id;
  logic [N_SRC-1:0]    o_pending;
  logic                o_any;
  logic                o_ack_err;

  modport master (
    output i_irq_raw, i_mode, i_mask, i_sw_set, i_ack, i_ack_id,
    input  o_pending, o_any, o_ack_err
  );

  modport slave (
    input  i_irq_raw, i_mode, i_mask, i_sw_set, i_ack, i_ack_id,
    output o_pending, o_any, o_ack_err
  );
endinterface

// File: rtl/vic_sync.sv
// Multi-bit flip-flop synchronizer chain; STAGES must be at least 2.
// Each bit is synchronized independently, so it is only safe for unrelated lines.
module vic_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] chain_q [STAGES];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int s = 0; s < STAGES; s++) chain_q[s] <= '0;
    end else begin
      chain_q[0] <= i_d;
      for (int s = 1; s < STAGES; s++) chain_q[s] <= chain_q[s-1];
    end
  end

  assign o_q = chain_q[STAGES-1];
endmodule

// File: rtl/vic_src_cond.sv
// Interrupt source conditioner: synchronizes raw lines, detects edges or levels,
// latches pending bits, applies the mask and handles acknowledge / ack errors.
module vic_src_cond
  import vic_pkg::*;
#(
  parameter int N_SRC       = vic_pkg::N_SRC,
  parameter int SYNC_STAGES = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  vic_src_cond_if.slave  bus
);
  logic [N_SRC-1:0] sync_q;
  logic [N_SRC-1:0] hist_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] ack_vec;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] level_set;
  logic             ack_err_q;
  logic             ack_err_d;

  vic_sync #(
    .WIDTH  (N_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (bus.i_irq_raw),
    .o_q   (sync_q)
  );

  // A held level would otherwise override every ack; the level term is suppressed
  // in the ack cycle so the bit drops for one cycle, while edges and sw_set still win.
  always_comb begin
    ack_vec   = '0;
    edge_set  = '0;
    level_set = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_vec[i]   = bus.i_ack && (bus.i_ack_id == IRQ_ID_W'(i));
      edge_set[i]  = (bus.i_mode[i] == MODE_EDGE)  && sync_q[i] && !hist_q[i];
      level_set[i] = (bus.i_mode[i] == MODE_LEVEL) && sync_q[i];
    end
    ack_clr   = ack_vec & pend_q;
    pend_d    = bus.i_sw_set | edge_set | ((level_set | pend_q) & ~ack_clr);
    ack_err_d = bus.i_ack && (ack_clr == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hist_q    <= '0;
      pend_q    <= '0;
      ack_err_q <= 1'b0;
    end else begin
      hist_q    <= sync_q;
      pend_q    <= pend_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign bus.o_pending = pend_q & bus.i_mask;
  assign bus.o_any     = |(pend_q & bus.i_mask);
  assign bus.o_ack_err = ack_err_q;
endmodule
